// File: rtl/spi_slave_param.sv
// SPI slave with configurable word width, clock polarity/phase and bit order.
// All SPI pins are synchronised into clk; every output is a clk-domain register.
module spi_slave_param #(
   parameter int   DATA_W    = 8,
   parameter logic CPOL      = 1'b0,
   parameter logic CPHA      = 1'b0,
   parameter logic LSB_FIRST = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              SCK,
   input  logic              MOSI,
   input  logic              SSEL,
   output logic              MISO,
   output logic [DATA_W-1:0] spi_data_out,
   output logic              spi_data_stb,
   input  logic [DATA_W-1:0] spi_data_in,
   input  logic              spi_data_valid,
   output logic              spi_data_load,
   output logic              spi_tx_underrun,
   output logic              spi_tsx_start,
   output logic              spi_tsx_end
);

   localparam int               CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   logic [2:0]        sck_q, ssel_q;
   logic [1:0]        mosi_q;
   logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
   logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
   logic [DATA_W-1:0] data_out_q, data_out_d;
   logic [DATA_W-1:0] rx_next;
   logic              miso_q, miso_d;
   logic              stb_q, load_q, underrun_q, start_q, end_q;

   logic active, ssel_fall, ssel_rise;
   logic lead_edge, trail_edge, sck_usable;
   logic sample_ev, drive_ev, load_ev, word_done;

   // NOTE: sequential state uses <= so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sck_q  <= {3{CPOL}};
         ssel_q <= 3'b111;
         mosi_q <= 2'b00;
      end else begin
         sck_q  <= {sck_q[1:0], SCK};
         ssel_q <= {ssel_q[1:0], SSEL};
         mosi_q <= {mosi_q[0], MOSI};
      end
   end

   assign active     = ~ssel_q[1];
   assign ssel_fall  = ssel_q[2] & ~ssel_q[1];
   assign ssel_rise  = ~ssel_q[2] & ssel_q[1];
   assign lead_edge  = (sck_q[2] == CPOL) && (sck_q[1] != CPOL);
   assign trail_edge = (sck_q[2] != CPOL) && (sck_q[1] == CPOL);

   // SCK edges count only inside a select window and never on its opening cycle.
   assign sck_usable = active & ~ssel_fall;
   assign sample_ev  = sck_usable & (CPHA ? trail_edge : lead_edge);
   assign drive_ev   = sck_usable & (CPHA ? lead_edge : trail_edge);
   assign load_ev    = (!CPHA && ssel_fall) || (drive_ev && (bit_cnt_q == '0));

   assign rx_next = LSB_FIRST ? {mosi_q[1], rx_shift_q[DATA_W-1:1]}
                              : {rx_shift_q[DATA_W-2:0], mosi_q[1]};

   // NOTE: every always_comb output gets a default first, so no latch is inferred.
   always_comb begin
      bit_cnt_d  = bit_cnt_q;
      rx_shift_d = rx_shift_q;
      tx_shift_d = tx_shift_q;
      data_out_d = data_out_q;
      word_done  = 1'b0;

      if (!active) begin
         bit_cnt_d = '0;
      end else if (sample_ev) begin
         rx_shift_d = rx_next;
         if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d  = '0;
            data_out_d = rx_next;
            word_done  = 1'b1;
         end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
         end
      end

      if (load_ev) begin
         tx_shift_d = spi_data_valid ? spi_data_in : '0;
      end else if (drive_ev) begin
         tx_shift_d = LSB_FIRST ? {1'b0, tx_shift_q[DATA_W-1:1]}
                                : {tx_shift_q[DATA_W-2:0], 1'b0};
      end

      miso_d = LSB_FIRST ? tx_shift_d[0] : tx_shift_d[DATA_W-1];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_cnt_q  <= '0;
         rx_shift_q <= '0;
         tx_shift_q <= '0;
         data_out_q <= '0;
         miso_q     <= 1'b0;
         stb_q      <= 1'b0;
         load_q     <= 1'b0;
         underrun_q <= 1'b0;
         start_q    <= 1'b0;
         end_q      <= 1'b0;
      end else begin
         bit_cnt_q  <= bit_cnt_d;
         rx_shift_q <= rx_shift_d;
         tx_shift_q <= tx_shift_d;
         data_out_q <= data_out_d;
         miso_q     <= miso_d;
         stb_q      <= word_done;
         load_q     <= load_ev;
         underrun_q <= load_ev & ~spi_data_valid;
         start_q    <= ssel_fall;
         end_q      <= ssel_rise;
      end
   end

   assign MISO            = miso_q;
   assign spi_data_out    = data_out_q;
   assign spi_data_stb    = stb_q;
   assign spi_data_load   = load_q;
   assign spi_tx_underrun = underrun_q;
   assign spi_tsx_start   = start_q;
   assign spi_tsx_end     = end_q;

endmodule

// File: tb/tb_spi_slave_param.sv
// Bench for spi_slave_param: a mode-0 8-bit MSB-first slave and a mode-3
// 16-bit LSB-first slave, each driven by a bit-banged master with a scoreboard.
module tb_spi_slave_param;

   localparam int H = 8;

   logic clk = 1'b0;
   logic rst;

   logic        sck0, mosi0, ssel0, miso0;
   logic [7:0]  dout0, din0;
   logic        valid0, stb0, load0, ur0, start0, end0;

   logic        sck1, mosi1, ssel1, miso1;
   logic [15:0] dout1, din1;
   logic        valid1, stb1, load1, ur1, start1, end1;

   int total = 0;
   int bad   = 0;

   logic [7:0]  q0[$];
   logic [15:0] q1[$];
   int n_stb0 = 0, n_load0 = 0, n_ur0 = 0, n_start0 = 0, n_end0 = 0;
   int n_stb1 = 0, n_load1 = 0, n_ur1 = 0, n_start1 = 0, n_end1 = 0;

   always #5 clk = ~clk;

   spi_slave_param #(.DATA_W(8), .CPOL(1'b0), .CPHA(1'b0), .LSB_FIRST(1'b0)) u_m0 (
      .clk(clk), .rst(rst), .SCK(sck0), .MOSI(mosi0), .SSEL(ssel0), .MISO(miso0),
      .spi_data_out(dout0), .spi_data_stb(stb0), .spi_data_in(din0),
      .spi_data_valid(valid0), .spi_data_load(load0), .spi_tx_underrun(ur0),
      .spi_tsx_start(start0), .spi_tsx_end(end0)
   );

   spi_slave_param #(.DATA_W(16), .CPOL(1'b1), .CPHA(1'b1), .LSB_FIRST(1'b1)) u_m3 (
      .clk(clk), .rst(rst), .SCK(sck1), .MOSI(mosi1), .SSEL(ssel1), .MISO(miso1),
      .spi_data_out(dout1), .spi_data_stb(stb1), .spi_data_in(din1),
      .spi_data_valid(valid1), .spi_data_load(load1), .spi_tx_underrun(ur1),
      .spi_tsx_start(start1), .spi_tsx_end(end1)
   );

   // Scoreboard: expected words are pushed by the tests, popped on each strobe.
   always @(negedge clk) begin
      if (!rst) begin
         if (stb0) begin
            n_stb0++;
            total++;
            if (q0.size() == 0) begin
               bad++;
               $display("FAIL rx0_unexpected: got %h want no strobe", dout0);
            end else begin
               logic [7:0] e0;
               e0 = q0.pop_front();
               if (dout0 !== e0) begin
                  bad++;
                  $display("FAIL rx0_word: got %h want %h", dout0, e0);
               end
            end
         end
         if (stb1) begin
            n_stb1++;
            total++;
            if (q1.size() == 0) begin
               bad++;
               $display("FAIL rx1_unexpected: got %h want no strobe", dout1);
            end else begin
               logic [15:0] e1;
               e1 = q1.pop_front();
               if (dout1 !== e1) begin
                  bad++;
                  $display("FAIL rx1_word: got %h want %h", dout1, e1);
               end
            end
         end
         if (load0)  n_load0++;
         if (ur0)    n_ur0++;
         if (start0) n_start0++;
         if (end0)   n_end0++;
         if (load1)  n_load1++;
         if (ur1)    n_ur1++;
         if (start1) n_start1++;
         if (end1)   n_end1++;
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_int(input string name, input int got, input int want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, got, want);
      end
   endtask

   // Mode-0 master: MOSI set while SCK low, MISO sampled just before the rise.
   // hold_last leaves SCK high after the final bit so no drive edge follows it.
   task automatic m0_bits(input logic [7:0] w, input int nbits, input bit hold_last,
                          input logic [7:0] next_din, output logic [7:0] miso_w);
      miso_w = '0;
      for (int i = 0; i < nbits; i++) begin
         mosi0 = w[7-i];
         if (i == nbits - 1) din0 = next_din;
         wait_cyc(H);
         miso_w = {miso_w[6:0], miso0};
         sck0 = 1'b1;
         wait_cyc(H);
         if (!(hold_last && i == nbits - 1)) sck0 = 1'b0;
      end
   endtask

   task automatic m0_begin();
      ssel0 = 1'b0;
      wait_cyc(2);
   endtask

   task automatic m0_end();
      wait_cyc(2);
      ssel0 = 1'b1;
      wait_cyc(H);
      sck0 = 1'b0;
      wait_cyc(H);
   endtask

   task automatic m0_word(input logic [7:0] w, output logic [7:0] miso_w);
      q0.push_back(w);
      m0_begin();
      m0_bits(w, 8, 1'b1, din0, miso_w);
      m0_end();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      wait_cyc(3);
      total++;
      if ({miso0, dout0, stb0, load0, ur0, start0, end0} !== 14'h0) begin
         bad++;
         $display("FAIL reset_m0: got %h want 0", {miso0, dout0, stb0, load0, ur0, start0, end0});
      end
      total++;
      if ({miso1, dout1, stb1, load1, ur1, start1, end1} !== 22'h0) begin
         bad++;
         $display("FAIL reset_m3: got %h want 0", {miso1, dout1, stb1, load1, ur1, start1, end1});
      end
      rst = 1'b0;
      wait_cyc(4);
   endtask

   task automatic test_mode0();
      logic [7:0] m;
      int s = n_stb0, l = n_load0, u = n_ur0, st = n_start0, e = n_end0;
      din0 = 8'h3C;
      valid0 = 1'b1;
      m0_word(8'hA5, m);
      total++;
      if (m !== 8'h3C) begin
         bad++;
         $display("FAIL m0_miso: got %h want 3c", m);
      end
      expect_int("m0_stb_count", n_stb0 - s, 1);
      expect_int("m0_load_count", n_load0 - l, 1);
      expect_int("m0_underrun_count", n_ur0 - u, 0);
      expect_int("m0_start_count", n_start0 - st, 1);
      expect_int("m0_end_count", n_end0 - e, 1);
      expect_int("m0_pending", q0.size(), 0);
      total++;
      if (dout0 !== 8'hA5) begin
         bad++;
         $display("FAIL m0_dout_hold: got %h want a5", dout0);
      end
   endtask

   task automatic test_mode3();
      logic [15:0] m;
      logic [15:0] w = 16'h1234;
      int s = n_stb1, l = n_load1;
      din1 = 16'hBEEF;
      valid1 = 1'b1;
      q1.push_back(w);
      ssel1 = 1'b0;
      wait_cyc(H);
      for (int i = 0; i < 16; i++) begin
         sck1 = 1'b0;
         mosi1 = w[i];
         wait_cyc(H);
         m[i] = miso1;
         sck1 = 1'b1;
         wait_cyc(H);
      end
      ssel1 = 1'b1;
      wait_cyc(H);
      total++;
      if (m !== 16'hBEEF) begin
         bad++;
         $display("FAIL m3_miso: got %h want beef", m);
      end
      expect_int("m3_stb_count", n_stb1 - s, 1);
      expect_int("m3_load_count", n_load1 - l, 1);
      expect_int("m3_pending", q1.size(), 0);
      total++;
      if (dout1 !== 16'h1234) begin
         bad++;
         $display("FAIL m3_dout: got %h want 1234", dout1);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] tx[3] = '{8'h81, 8'h42, 8'h24};
      logic [7:0] rx[3] = '{8'h01, 8'h02, 8'h03};
      logic [7:0] m;
      int s = n_stb0, l = n_load0;
      din0 = tx[0];
      valid0 = 1'b1;
      m0_begin();
      for (int k = 0; k < 3; k++) begin
         q0.push_back(rx[k]);
         m0_bits(rx[k], 8, k == 2, (k < 2) ? tx[k+1] : tx[2], m);
         total++;
         if (m !== tx[k]) begin
            bad++;
            $display("FAIL b2b_miso[%0d]: got %h want %h", k, m, tx[k]);
         end
      end
      m0_end();
      expect_int("b2b_stb_count", n_stb0 - s, 3);
      expect_int("b2b_load_count", n_load0 - l, 3);
      expect_int("b2b_pending", q0.size(), 0);
   endtask

   task automatic test_underrun();
      logic [7:0] m;
      int l = n_load0, u = n_ur0;
      din0 = 8'hFF;
      valid0 = 1'b0;
      m0_word(8'h77, m);
      valid0 = 1'b1;
      total++;
      if (m !== 8'h00) begin
         bad++;
         $display("FAIL ur_miso: got %h want 00", m);
      end
      expect_int("ur_underrun_count", n_ur0 - u, 1);
      expect_int("ur_load_count", n_load0 - l, 1);
      expect_int("ur_pending", q0.size(), 0);
   endtask

   task automatic test_partial();
      logic [7:0] m;
      int s = n_stb0, e = n_end0;
      din0 = 8'h3C;
      m0_begin();
      m0_bits(8'hE7, 5, 1'b0, 8'h3C, m);
      m0_end();
      expect_int("partial_stb_count", n_stb0 - s, 0);
      expect_int("partial_end_count", n_end0 - e, 1);
      s = n_stb0;
      m0_word(8'h5A, m);
      expect_int("after_partial_stb", n_stb0 - s, 1);
      expect_int("after_partial_pending", q0.size(), 0);
      total++;
      if (dout0 !== 8'h5A) begin
         bad++;
         $display("FAIL after_partial_dout: got %h want 5a", dout0);
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] m;
      int s, l;
      m0_begin();
      m0_bits(8'hFF, 3, 1'b1, din0, m);
      rst = 1'b1;
      wait_cyc(2);
      total++;
      if ({miso0, dout0, stb0, load0, ur0, start0, end0} !== 14'h0) begin
         bad++;
         $display("FAIL midrst_outputs: got %h want 0", {miso0, dout0, stb0, load0, ur0, start0, end0});
      end
      ssel0 = 1'b1;
      sck0 = 1'b0;
      wait_cyc(4);
      rst = 1'b0;
      s = n_stb0;
      l = n_load0;
      wait_cyc(20);
      expect_int("midrst_idle_stb", n_stb0 - s, 0);
      expect_int("midrst_idle_load", n_load0 - l, 0);
      m0_word(8'hC3, m);
      expect_int("midrst_stb_count", n_stb0 - s, 1);
      expect_int("midrst_pending", q0.size(), 0);
      total++;
      if (dout0 !== 8'hC3) begin
         bad++;
         $display("FAIL midrst_dout: got %h want c3", dout0);
      end
   endtask

   initial begin
      rst = 1'b1;
      sck0 = 1'b0; mosi0 = 1'b0; ssel0 = 1'b1; din0 = '0; valid0 = 1'b0;
      sck1 = 1'b1; mosi1 = 1'b0; ssel1 = 1'b1; din1 = '0; valid1 = 1'b0;
      test_reset();
      test_mode0();
      test_mode3();
      test_back_to_back();
      test_underrun();
      test_partial();
      test_reset_mid();
      wait_cyc(4);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
